// File: rtl/mipi_csi_packet_decoder_vc.sv
// CSI-2 long/short packet decoder sitting behind the lane aligner.
// Locks onto the sync beat that follows a valid-low gap, gathers the 4-byte
// packet header, and then does one of three things with the packet:
// streams its payload with byte enables and a last flag, pulses FS/FE for a
// frame short packet, or drops it.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT_GAP   | after reset; ignore beats until data_valid_i drops
// IDLE       | between bursts; next valid beat is checked for the sync byte
// HDR        | collecting header bytes hb0..hb3, LANES bytes per beat
// PAYLOAD    | forwarding payload beats until the word count is exhausted
// SKIP       | discarding the rest of the burst (footer, short or rejected)
module mipi_csi_packet_decoder_vc #(
  parameter int         LANES        = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter logic [5:0] DT_LO        = 6'h2A,
  parameter logic [5:0] DT_HI        = 6'h2D,
  parameter bit         VC_FILTER_EN = 1'b0,
  parameter logic [1:0] VC_SEL       = 2'd0
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 data_valid_i,
  input  logic [8*LANES-1:0]   data_i,
  output logic                 output_valid_o,
  output logic [8*LANES-1:0]   data_o,
  output logic [LANES-1:0]     byte_en_o,
  output logic                 last_o,
  output logic [15:0]          packet_length_o,
  output logic [5:0]           packet_type_o,
  output logic [1:0]           virtual_channel_o,
  output logic                 frame_start_o,
  output logic                 frame_end_o,
  output logic                 error_o
);

  localparam logic [15:0] LANES_W = 16'(LANES);
  localparam logic [3:0]  LANES_H = 4'(LANES);
  localparam logic [2:0]  LANES_C = 3'(LANES);

  typedef enum logic [2:0] {
    ST_WAIT_GAP,
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_SKIP
  } state_t;

  state_t               state_q, state_d;
  logic                 first_beat_q, first_beat_d;
  logic [2:0]           hdr_cnt_q, hdr_cnt_d;
  logic [3:0][7:0]      hb_q, hb_d, hb_next;
  logic [15:0]          rem_q, rem_d;
  logic                 valid_q, valid_d;
  logic [8*LANES-1:0]   data_q, data_d;
  logic [LANES-1:0]     be_q, be_d;
  logic                 last_q, last_d;
  logic [15:0]          len_q, len_d;
  logic [5:0]           type_q, type_d;
  logic [1:0]           vc_q, vc_d;
  logic                 fs_q, fs_d;
  logic                 fe_q, fe_d;
  logic                 err_q, err_d;

  logic                 hdr_done;
  logic [5:0]           hdr_dt;
  logic [1:0]           hdr_vc;
  logic [15:0]          hdr_wc;
  logic                 hdr_accept;

  // Merge the current beat into the header bytes collected so far and decode.
  always_comb begin
    hb_next = hb_q;
    for (int i = 0; i < LANES; i++) begin
      hb_next[2'(hdr_cnt_q + 3'(i))] = data_i[8*i +: 8];
    end
    hdr_done   = ({1'b0, hdr_cnt_q} + LANES_H) >= 4'd4;
    hdr_dt     = hb_next[0][5:0];
    hdr_vc     = hb_next[0][7:6];
    hdr_wc     = {hb_next[2], hb_next[1]};
    hdr_accept = (hdr_dt >= DT_LO) && (hdr_dt <= DT_HI) &&
                 (!VC_FILTER_EN || (hdr_vc == VC_SEL)) &&
                 (hdr_wc != 16'd0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    first_beat_d = !data_valid_i;
    hdr_cnt_d    = hdr_cnt_q;
    hb_d         = hb_q;
    rem_d        = rem_q;
    valid_d      = 1'b0;
    data_d       = '0;
    be_d         = '0;
    last_d       = 1'b0;
    fs_d         = 1'b0;
    fe_d         = 1'b0;
    err_d        = 1'b0;
    len_d        = len_q;
    type_d       = type_q;
    vc_d         = vc_q;
    // Packet metadata lives from header acceptance through last_o / error_o.
    if (last_q || err_q) begin
      len_d  = '0;
      type_d = '0;
      vc_d   = '0;
    end

    case (state_q)
      ST_WAIT_GAP: begin
        if (!data_valid_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (data_valid_i) begin
          if (first_beat_q && (data_i[7:0] == SYNC_BYTE)) begin
            state_d   = ST_HDR;
            hdr_cnt_d = '0;
          end else begin
            state_d = ST_SKIP;
          end
        end
      end
      ST_HDR: begin
        if (!data_valid_i) begin
          state_d = ST_IDLE;
        end else begin
          hb_d = hb_next;
          if (!hdr_done) begin
            hdr_cnt_d = hdr_cnt_q + LANES_C;
          end else begin
            hdr_cnt_d = '0;
            state_d   = ST_SKIP;
            if (hdr_dt <= 6'h0F) begin
              fs_d = (hdr_dt == 6'h00);
              fe_d = (hdr_dt == 6'h01);
            end else if (hdr_accept) begin
              len_d   = hdr_wc;
              type_d  = hdr_dt;
              vc_d    = hdr_vc;
              rem_d   = hdr_wc;
              state_d = ST_PAYLOAD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (!data_valid_i) begin
          err_d   = (rem_q != 16'd0);
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
          data_d  = data_i;
          for (int i = 0; i < LANES; i++) begin
            be_d[i] = (rem_q > 16'(i));
          end
          last_d = (rem_q <= LANES_W);
          if (last_d) begin
            rem_d   = '0;
            state_d = ST_SKIP;
          end else begin
            rem_d = rem_q - LANES_W;
          end
        end
      end
      ST_SKIP: begin
        if (!data_valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT_GAP;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_WAIT_GAP;
      first_beat_q <= 1'b0;
      hdr_cnt_q    <= '0;
      hb_q         <= '0;
      rem_q        <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      be_q         <= '0;
      last_q       <= 1'b0;
      len_q        <= '0;
      type_q       <= '0;
      vc_q         <= '0;
      fs_q         <= 1'b0;
      fe_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_beat_q <= first_beat_d;
      hdr_cnt_q    <= hdr_cnt_d;
      hb_q         <= hb_d;
      rem_q        <= rem_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      be_q         <= be_d;
      last_q       <= last_d;
      len_q        <= len_d;
      type_q       <= type_d;
      vc_q         <= vc_d;
      fs_q         <= fs_d;
      fe_q         <= fe_d;
      err_q        <= err_d;
    end
  end

  assign output_valid_o    = valid_q;
  assign data_o            = data_q;
  assign byte_en_o         = be_q;
  assign last_o            = last_q;
  assign packet_length_o   = len_q;
  assign packet_type_o     = type_q;
  assign virtual_channel_o = vc_q;
  assign frame_start_o     = fs_q;
  assign frame_end_o       = fe_q;
  assign error_o           = err_q;

endmodule

// File: tb/tb_mipi_csi_packet_decoder_vc.sv
// Bench for the CSI-2 packet decoder: a 4-lane instance, a 4-lane instance
// filtering on VC 1 (sharing the 4-lane stimulus) and a 2-lane instance.
module tb_mipi_csi_packet_decoder_vc;

  typedef logic [7:0]  bq_t [$];
  typedef logic [63:0] rq_t [$];

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic v4 = 1'b0, v2 = 1'b0;
  logic [31:0] d4 = '0;
  logic [15:0] d2 = '0;
  int cyc = 0;

  logic o4_valid, o4_last, o4_fs, o4_fe, o4_err;
  logic [31:0] o4_data; logic [3:0] o4_be; logic [15:0] o4_len; logic [5:0] o4_type; logic [1:0] o4_vc;
  logic o4v_valid, o4v_last, o4v_fs, o4v_fe, o4v_err;
  logic [31:0] o4v_data; logic [3:0] o4v_be; logic [15:0] o4v_len; logic [5:0] o4v_type; logic [1:0] o4v_vc;
  logic o2_valid, o2_last, o2_fs, o2_fe, o2_err;
  logic [15:0] o2_data; logic [1:0] o2_be; logic [15:0] o2_len; logic [5:0] o2_type; logic [1:0] o2_vc;

  int vectors = 0, miscompares = 0;

  rq_t obs4, obs4v, obs2, exp4, exp4v, exp2;
  int  obs4_cyc [$];
  int  fs4 = 0, fe4 = 0, er4 = 0, bad4 = 0, fs4_cyc = 0;
  int  fs4v = 0, fe4v = 0, er4v = 0, bad4v = 0;
  int  fs2 = 0, fe2 = 0, er2 = 0, bad2 = 0;
  int  efs4 = 0, efe4 = 0, eer4 = 0, efs4v = 0, efe4v = 0, eer4v = 0, efs2 = 0, efe2 = 0, eer2 = 0;

  mipi_csi_packet_decoder_vc #(.LANES(4)) dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(v4), .data_i(d4),
    .output_valid_o(o4_valid), .data_o(o4_data), .byte_en_o(o4_be), .last_o(o4_last),
    .packet_length_o(o4_len), .packet_type_o(o4_type), .virtual_channel_o(o4_vc),
    .frame_start_o(o4_fs), .frame_end_o(o4_fe), .error_o(o4_err));

  mipi_csi_packet_decoder_vc #(.LANES(4), .VC_FILTER_EN(1'b1), .VC_SEL(2'd1)) dut4v (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(v4), .data_i(d4),
    .output_valid_o(o4v_valid), .data_o(o4v_data), .byte_en_o(o4v_be), .last_o(o4v_last),
    .packet_length_o(o4v_len), .packet_type_o(o4v_type), .virtual_channel_o(o4v_vc),
    .frame_start_o(o4v_fs), .frame_end_o(o4v_fe), .error_o(o4v_err));

  mipi_csi_packet_decoder_vc #(.LANES(2)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(v2), .data_i(d2),
    .output_valid_o(o2_valid), .data_o(o2_data), .byte_en_o(o2_be), .last_o(o2_last),
    .packet_length_o(o2_len), .packet_type_o(o2_type), .virtual_channel_o(o2_vc),
    .frame_start_o(o2_fs), .frame_end_o(o2_fe), .error_o(o2_err));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mk_rec(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] len,
                                         input logic last, input logic [3:0] be, input logic [31:0] data);
    return {3'b000, vc, dt, len, last, be, data};
  endfunction

  // Output monitors: record payload beats, count pulses, flag non-zero idle outputs.
  always @(negedge clk) begin
    if (o4_valid) begin
      obs4.push_back(mk_rec(o4_vc, o4_type, o4_len, o4_last, o4_be, o4_data));
      obs4_cyc.push_back(cyc);
    end else if ({o4_data, o4_be, o4_last} !== '0) bad4++;
    if (o4_fs) begin fs4++; fs4_cyc = cyc; end
    if (o4_fe) fe4++;
    if (o4_err) er4++;
  end

  always @(negedge clk) begin
    if (o4v_valid) obs4v.push_back(mk_rec(o4v_vc, o4v_type, o4v_len, o4v_last, o4v_be, o4v_data));
    else if ({o4v_data, o4v_be, o4v_last} !== '0) bad4v++;
    if (o4v_fs) fs4v++;
    if (o4v_fe) fe4v++;
    if (o4v_err) er4v++;
  end

  always @(negedge clk) begin
    if (o2_valid) obs2.push_back(mk_rec(o2_vc, o2_type, o2_len, o2_last, {2'b00, o2_be}, {16'h0000, o2_data}));
    else if ({o2_data, o2_be, o2_last} !== '0) bad2++;
    if (o2_fs) fs2++;
    if (o2_fe) fe2++;
    if (o2_err) er2++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Burst bytes: sync beat, header (DI, WC lo, WC hi, ECC), nbytes payload/footer, padding.
  function automatic bq_t build_burst(input int lanes, input logic [7:0] lead, input logic [7:0] di,
                                      input logic [15:0] wc, input int nbytes, input bit fill_b8);
    bq_t q;
    for (int i = 0; i < lanes; i++) q.push_back(lead);
    q.push_back(di);
    q.push_back(wc[7:0]);
    q.push_back(wc[15:8]);
    q.push_back(8'($urandom));
    for (int i = 0; i < nbytes; i++) q.push_back(fill_b8 ? 8'hB8 : 8'($urandom));
    while ((q.size() % lanes) != 0) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic logic [31:0] beat4(input bq_t b, input int k);
    return {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
  endfunction

  function automatic void push_exp(input int tgt, input logic [63:0] r);
    if (tgt == 0) exp4.push_back(r);
    else if (tgt == 1) exp4v.push_back(r);
    else exp2.push_back(r);
  endfunction

  function automatic void add_pulse(input int tgt, input int kind);
    case ({tgt[1:0], kind[1:0]})
      4'b0000: efs4++;  4'b0001: efe4++;  4'b0010: eer4++;
      4'b0100: efs4v++; 4'b0101: efe4v++; 4'b0110: eer4v++;
      4'b1000: efs2++;  4'b1001: efe2++;  default: eer2++;
    endcase
  endfunction

  // Packet-level reference: what one burst (preceded by a gap) must produce.
  function automatic void model(input int tgt, input int lanes, input bq_t b, input bit vf, input logic [1:0] vs);
    int n, p, rem;
    logic [5:0] dt; logic [1:0] vc; logic [15:0] wc;
    logic [31:0] data; logic [3:0] be;
    n = b.size();
    if (n < lanes + 4 || b[0] != 8'hB8) return;
    dt = b[lanes][5:0];
    vc = b[lanes][7:6];
    wc = {b[lanes+2], b[lanes+1]};
    if (dt <= 6'h0F) begin
      if (dt == 6'h00) add_pulse(tgt, 0);
      if (dt == 6'h01) add_pulse(tgt, 1);
      return;
    end
    if (dt < 6'h2A || dt > 6'h2D || (vf && vc != vs) || wc == 16'd0) return;
    p = lanes + 4;
    rem = int'(wc);
    while (rem > 0) begin
      if (p + lanes > n) begin
        add_pulse(tgt, 2);
        return;
      end
      data = '0;
      be = '0;
      for (int i = 0; i < lanes; i++) begin
        data[8*i +: 8] = b[p+i];
        be[i] = (i < rem);
      end
      push_exp(tgt, mk_rec(vc, dt, wc, rem <= lanes, be, data));
      rem = (rem > lanes) ? rem - lanes : 0;
      p += lanes;
    end
  endfunction

  task automatic drive_burst(input int lanes, input bq_t b, output int start_cyc);
    int nb;
    nb = b.size() / lanes;
    start_cyc = 0;
    for (int k = 0; k < nb; k++) begin
      @(posedge clk); #1;
      if (k == 0) start_cyc = cyc;
      if (lanes == 4) begin v4 = 1'b1; d4 = beat4(b, k); end
      else begin v2 = 1'b1; d2 = {b[2*k+1], b[2*k]}; end
    end
    @(posedge clk); #1;
    v4 = 1'b0; v2 = 1'b0; d4 = '0; d2 = '0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o4_valid, o4_data, o4_be, o4_last, o4_len, o4_type, o4_vc, o4_fs, o4_fe, o4_err} !== '0) begin
      miscompares++; $display("FAIL reset_dut4: got %h want 0", {o4_valid, o4_data, o4_be, o4_len, o4_type}); end
    vectors++;
    if ({o4v_valid, o4v_data, o4v_be, o4v_last, o4v_len, o4v_type, o4v_vc, o4v_fs, o4v_fe, o4v_err} !== '0) begin
      miscompares++; $display("FAIL reset_dut4v: got %h want 0", {o4v_valid, o4v_data, o4v_len}); end
    vectors++;
    if ({o2_valid, o2_data, o2_be, o2_last, o2_len, o2_type, o2_vc, o2_fs, o2_fe, o2_err} !== '0) begin
      miscompares++; $display("FAIL reset_dut2: got %h want 0", {o2_valid, o2_data, o2_len}); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_long_lanes4;
    bq_t b; int s, base, basev, n;
    b = build_burst(4, 8'hB8, 8'h2B, 16'h0140, 322, 1'b0);
    base = obs4.size(); basev = obs4v.size();
    drive_burst(4, b, s);
    n = obs4.size() - base;
    vectors++;
    if (n !== 80) begin miscompares++; $display("FAIL t1_beats: got %0d want 80", n); end
    for (int k = 0; k < ((n < 80) ? n : 80); k++) begin
      vectors++;
      if (obs4[base+k] !== mk_rec(2'd0, 6'h2B, 16'h0140, k == 79, 4'hF, beat4(b, k + 2))) begin
        miscompares++; $display("FAIL t1_beat%0d: got %h want %h", k, obs4[base+k],
                                mk_rec(2'd0, 6'h2B, 16'h0140, k == 79, 4'hF, beat4(b, k + 2))); end
    end
    if (n > 0) begin
      vectors++;
      if (obs4_cyc[base] !== s + 3) begin
        miscompares++; $display("FAIL t1_latency: got cycle %0d want %0d", obs4_cyc[base], s + 3); end
    end
    vectors++;
    if ({o4_len, o4_type, o4_vc} !== '0) begin
      miscompares++; $display("FAIL t1_meta_clear: got %h want 0", {o4_len, o4_type, o4_vc}); end
    vectors++;
    if (obs4v.size() - basev !== 0) begin
      miscompares++; $display("FAIL t1_vc_filtered: got %0d beats want 0", obs4v.size() - basev); end
  endtask

  task automatic test_lanes2;
    bq_t b; int s, base, n;
    logic [1:0] be_exp [3];
    be_exp[0] = 2'b11; be_exp[1] = 2'b11; be_exp[2] = 2'b01;
    b = build_burst(2, 8'hB8, 8'h2C, 16'd5, 7, 1'b0);
    base = obs2.size();
    drive_burst(2, b, s);
    n = obs2.size() - base;
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL t2_beats: got %0d want 3", n); end
    for (int k = 0; k < ((n < 3) ? n : 3); k++) begin
      vectors++;
      if (obs2[base+k] !== mk_rec(2'd0, 6'h2C, 16'd5, k == 2, {2'b00, be_exp[k]}, {16'h0, b[6+2*k+1], b[6+2*k]})) begin
        miscompares++; $display("FAIL t2_beat%0d: got %h want be %b last %0d", k, obs2[base+k], be_exp[k], k == 2); end
    end
  endtask

  task automatic test_fs_fe;
    bq_t b; int s, base, f0, e0, fv0;
    base = obs4.size(); f0 = fs4; e0 = fe4; fv0 = fs4v;
    b = build_burst(4, 8'hB8, 8'h00, 16'h0007, 0, 1'b0);
    drive_burst(4, b, s);
    vectors++;
    if (fs4_cyc !== s + 2) begin miscompares++; $display("FAIL t3_fs_latency: got %0d want %0d", fs4_cyc, s + 2); end
    b = build_burst(4, 8'hB8, 8'h01, 16'h0007, 0, 1'b0);
    drive_burst(4, b, s);
    vectors++;
    if (fs4 - f0 !== 1) begin miscompares++; $display("FAIL t3_fs_count: got %0d want 1", fs4 - f0); end
    vectors++;
    if (fe4 - e0 !== 1) begin miscompares++; $display("FAIL t3_fe_count: got %0d want 1", fe4 - e0); end
    vectors++;
    if (fs4v - fv0 !== 1) begin miscompares++; $display("FAIL t3_fs_count_vc: got %0d want 1", fs4v - fv0); end
    vectors++;
    if (obs4.size() - base !== 0) begin miscompares++; $display("FAIL t3_no_output: got %0d beats want 0", obs4.size() - base); end
  endtask

  task automatic test_vc_filter;
    bq_t b1, b2; int s, base, basev, n;
    b1 = build_burst(4, 8'hB8, 8'h2B, 16'd16, 18, 1'b0);
    b2 = build_burst(4, 8'hB8, 8'h6B, 16'd16, 18, 1'b0);
    base = obs4.size(); basev = obs4v.size();
    drive_burst(4, b1, s);
    drive_burst(4, b2, s);
    n = obs4v.size() - basev;
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL t4_filtered_beats: got %0d want 4", n); end
    for (int k = 0; k < ((n < 4) ? n : 4); k++) begin
      vectors++;
      if (obs4v[basev+k] !== mk_rec(2'd1, 6'h2B, 16'd16, k == 3, 4'hF, beat4(b2, k + 2))) begin
        miscompares++; $display("FAIL t4_beat%0d: got %h want vc 1 data %h", k, obs4v[basev+k], beat4(b2, k + 2)); end
    end
    vectors++;
    if (obs4.size() - base !== 8) begin miscompares++; $display("FAIL t4_unfiltered_beats: got %0d want 8", obs4.size() - base); end
  endtask

  task automatic test_error;
    bq_t b; int s, base, er0, n;
    b = build_burst(4, 8'hB8, 8'h2B, 16'd64, 32, 1'b0);
    base = obs4.size(); er0 = er4;
    drive_burst(4, b, s);
    n = obs4.size() - base;
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL t5_beats: got %0d want 8", n); end
    for (int k = 0; k < ((n < 8) ? n : 8); k++) begin
      vectors++;
      if (obs4[base+k] !== mk_rec(2'd0, 6'h2B, 16'd64, 1'b0, 4'hF, beat4(b, k + 2))) begin
        miscompares++; $display("FAIL t5_beat%0d: got %h want no last", k, obs4[base+k]); end
    end
    vectors++;
    if (er4 - er0 !== 1) begin miscompares++; $display("FAIL t5_error_count: got %0d want 1", er4 - er0); end
    vectors++;
    if ({o4_len, o4_type} !== '0) begin miscompares++; $display("FAIL t5_meta_clear: got %h want 0", {o4_len, o4_type}); end
    b = build_burst(4, 8'hB8, 8'h2B, 16'd8, 10, 1'b0);
    base = obs4.size();
    drive_burst(4, b, s);
    vectors++;
    if (obs4.size() - base !== 2) begin miscompares++; $display("FAIL t5_recover_beats: got %0d want 2", obs4.size() - base); end
    else begin
      vectors++;
      if (obs4[base+1] !== mk_rec(2'd0, 6'h2B, 16'd8, 1'b1, 4'hF, beat4(b, 3))) begin
        miscompares++; $display("FAIL t5_recover_last: got %h", obs4[base+1]); end
    end
    vectors++;
    if (er4 - er0 !== 1) begin miscompares++; $display("FAIL t5_no_extra_error: got %0d want 1", er4 - er0); end
  endtask

  task automatic test_reset_mid;
    bq_t b; int s, base, er0, n, f0, e0;
    b = build_burst(4, 8'hB8, 8'h2B, 16'h0040, 66, 1'b0);
    base = obs4.size(); er0 = er4;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1; v4 = 1'b1; d4 = beat4(b, k);
    end
    @(posedge clk); #1; d4 = beat4(b, 6);
    @(negedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; d4 = beat4(b, 7);
    @(posedge clk); #1; d4 = beat4(b, 8);
    @(negedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; d4 = 32'hB8B8_B8B8;
    @(posedge clk); #1; d4 = 32'h0000_402B;
    @(posedge clk); #1; d4 = beat4(b, 9);
    @(posedge clk); #1; v4 = 1'b0; d4 = '0;
    repeat (4) @(posedge clk);
    n = obs4.size() - base;
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL t6_beats_before_reset: got %0d want 4", n); end
    for (int k = 0; k < ((n < 4) ? n : 4); k++) begin
      vectors++;
      if (obs4[base+k] !== mk_rec(2'd0, 6'h2B, 16'h0040, 1'b0, 4'hF, beat4(b, k + 2))) begin
        miscompares++; $display("FAIL t6_beat%0d: got %h", k, obs4[base+k]); end
    end
    vectors++;
    if (er4 - er0 !== 0) begin miscompares++; $display("FAIL t6_error: got %0d want 0", er4 - er0); end
    base = obs4.size(); f0 = fs4; e0 = fe4;
    b = build_burst(4, 8'hB8, 8'h12, 16'd16, 18, 1'b1);
    drive_burst(4, b, s);
    vectors++;
    if ((obs4.size() - base) + (fs4 - f0) + (fe4 - e0) !== 0) begin
      miscompares++; $display("FAIL t6_dt12_ignored: got %0d events want 0", (obs4.size() - base) + (fs4 - f0) + (fe4 - e0)); end
    base = obs4.size();
    b = build_burst(4, 8'hB8, 8'h2A, 16'd16, 18, 1'b1);
    drive_burst(4, b, s);
    n = obs4.size() - base;
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL t6_b8_payload_beats: got %0d want 4", n); end
    else begin
      vectors++;
      if (obs4[base+3] !== mk_rec(2'd0, 6'h2A, 16'd16, 1'b1, 4'hF, 32'hB8B8_B8B8)) begin
        miscompares++; $display("FAIL t6_b8_payload_last: got %h", obs4[base+3]); end
    end
  endtask

  task automatic test_random;
    bq_t b; int s, b4, b4v, b2, n, lanes, wc, nbytes;
    int f4, e4, r4, f4v, e4v, r4v, f2, e2, r2;
    logic [5:0] dts [0:7];
    logic [7:0] lead, di;
    dts[0] = 6'h00; dts[1] = 6'h01; dts[2] = 6'h12; dts[3] = 6'h2A;
    dts[4] = 6'h2B; dts[5] = 6'h2C; dts[6] = 6'h2D; dts[7] = 6'h30;
    b4 = obs4.size(); b4v = obs4v.size(); b2 = obs2.size();
    f4 = fs4; e4 = fe4; r4 = er4; f4v = fs4v; e4v = fe4v; r4v = er4v; f2 = fs2; e2 = fe2; r2 = er2;
    for (int t = 0; t < 60; t++) begin
      lanes = ($urandom_range(0, 1) == 0) ? 4 : 2;
      di = {2'($urandom), ($urandom_range(0, 9) < 8) ? dts[$urandom_range(0, 7)] : 6'($urandom)};
      wc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 48);
      nbytes = ($urandom_range(0, 6) == 0) ? $urandom_range(0, wc + 2) : wc + 2;
      lead = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 8'hB7)) : 8'hB8;
      b = build_burst(lanes, lead, di, 16'(wc), nbytes, $urandom_range(0, 9) == 0);
      if (lanes == 4) begin
        model(0, 4, b, 1'b0, 2'd0);
        model(1, 4, b, 1'b1, 2'd1);
      end else begin
        model(2, 2, b, 1'b0, 2'd0);
      end
      drive_burst(lanes, b, s);
    end
    n = obs4.size() - b4;
    vectors++;
    if (n !== exp4.size()) begin miscompares++; $display("FAIL rnd_dut4_count: got %0d want %0d", n, exp4.size()); end
    for (int k = 0; k < ((n < exp4.size()) ? n : exp4.size()); k++) begin
      vectors++;
      if (obs4[b4+k] !== exp4[k]) begin miscompares++; $display("FAIL rnd_dut4_beat%0d: got %h want %h", k, obs4[b4+k], exp4[k]); end
    end
    n = obs4v.size() - b4v;
    vectors++;
    if (n !== exp4v.size()) begin miscompares++; $display("FAIL rnd_dut4v_count: got %0d want %0d", n, exp4v.size()); end
    for (int k = 0; k < ((n < exp4v.size()) ? n : exp4v.size()); k++) begin
      vectors++;
      if (obs4v[b4v+k] !== exp4v[k]) begin miscompares++; $display("FAIL rnd_dut4v_beat%0d: got %h want %h", k, obs4v[b4v+k], exp4v[k]); end
    end
    n = obs2.size() - b2;
    vectors++;
    if (n !== exp2.size()) begin miscompares++; $display("FAIL rnd_dut2_count: got %0d want %0d", n, exp2.size()); end
    for (int k = 0; k < ((n < exp2.size()) ? n : exp2.size()); k++) begin
      vectors++;
      if (obs2[b2+k] !== exp2[k]) begin miscompares++; $display("FAIL rnd_dut2_beat%0d: got %h want %h", k, obs2[b2+k], exp2[k]); end
    end
    vectors++;
    if ({fs4 - f4, fe4 - e4, er4 - r4} !== {efs4, efe4, eer4}) begin
      miscompares++; $display("FAIL rnd_dut4_pulses: got fs %0d fe %0d err %0d want %0d %0d %0d", fs4 - f4, fe4 - e4, er4 - r4, efs4, efe4, eer4); end
    vectors++;
    if ({fs4v - f4v, fe4v - e4v, er4v - r4v} !== {efs4v, efe4v, eer4v}) begin
      miscompares++; $display("FAIL rnd_dut4v_pulses: got fs %0d fe %0d err %0d want %0d %0d %0d", fs4v - f4v, fe4v - e4v, er4v - r4v, efs4v, efe4v, eer4v); end
    vectors++;
    if ({fs2 - f2, fe2 - e2, er2 - r2} !== {efs2, efe2, eer2}) begin
      miscompares++; $display("FAIL rnd_dut2_pulses: got fs %0d fe %0d err %0d want %0d %0d %0d", fs2 - f2, fe2 - e2, er2 - r2, efs2, efe2, eer2); end
    vectors++;
    if (bad4 + bad4v + bad2 !== 0) begin
      miscompares++; $display("FAIL idle_outputs_zero: got %0d nonzero idle cycles want 0", bad4 + bad4v + bad2); end
  endtask

  initial begin
    test_reset();
    test_long_lanes4();
    test_lanes2();
    test_fs_fe();
    test_vc_filter();
    test_error();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
